// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Sequential instruction prefetcher. Drives a word-aligned fetch address to a
// read-only instruction memory, samples the returned word after RD_WAIT cycles
// and pushes {word, address} into a small FIFO that the decode stage drains
// with a valid/ready handshake. A one-cycle Redirect flushes the FIFO and
// restarts fetching at a new address.
//
// Ports
//   CLK         in   1   rising-edge clock
//   Reset_L     in   1   asynchronous active-low reset
//   Address     out  64  fetch address to instruction memory, bits [1:0] = 0
//   Data        in   32  instruction word for Address
//   Redirect    in   1   branch/exception redirect strobe (one cycle)
//   RedirectPC  in   64  new fetch address, used when Redirect = 1
//   InstrValid  out  1   head FIFO entry is valid
//   InstrReady  in   1   consumer accepts the head entry
//   Instr       out  32  head instruction word
//   InstrPC     out  64  address of the head instruction
//   Count       out  clog2(FIFO_DEPTH)+1  FIFO occupancy
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_WAIT    = 1,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic                          CLK,
    input  logic                          Reset_L,
    output logic [63:0]                   Address,
    input  logic [31:0]                   Data,
    input  logic                          Redirect,
    input  logic [63:0]                   RedirectPC,
    output logic                          InstrValid,
    input  logic                          InstrReady,
    output logic [31:0]                   Instr,
    output logic [63:0]                   InstrPC,
    output logic [$clog2(FIFO_DEPTH):0]   Count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    localparam logic [63:0]       RESET_PC_AL = {RESET_PC[63:2], 2'b00};
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

    typedef enum logic {StFetch, StStall} state_e;

    state_e            r_state;
    logic [63:0]       r_fetch_pc;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_mem_instr [FIFO_DEPTH];
    logic [63:0]       r_mem_pc    [FIFO_DEPTH];

    state_e            w_state_nxt;
    logic [63:0]       w_pc_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_full;
    logic              w_sample;
    logic              w_unused;

    // Redirect address bits [1:0] are dropped by alignment.
    assign w_unused = ^RedirectPC[1:0];

    assign w_full   = (r_count == CNT_FULL);
    assign w_sample = (r_state == StFetch) && (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_fetch_pc;
        w_wait_nxt  = r_wait_cnt;
        w_push      = 1'b0;
        w_pop       = InstrValid && InstrReady;
        w_flush     = 1'b0;

        unique case (r_state)
            StFetch: begin
                if (w_sample) begin
                    // Full with no pop: park the address and wait for space.
                    if (w_full && !w_pop) begin
                        w_state_nxt = StStall;
                    end else begin
                        w_push = 1'b1;
                    end
                end else begin
                    w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            StStall: begin
                // Address has been stable long enough; Data is already good.
                if (w_pop) begin
                    w_push      = 1'b1;
                    w_state_nxt = StFetch;
                end
            end
            default: w_state_nxt = StFetch;
        endcase

        if (w_push) begin
            w_pc_nxt   = r_fetch_pc + 64'd4;
            w_wait_nxt = '0;
        end

        // Redirect overrides everything fetched or consumed this cycle.
        if (Redirect) begin
            w_push      = 1'b0;
            w_pop       = 1'b0;
            w_flush     = 1'b1;
            w_pc_nxt    = {RedirectPC[63:2], 2'b00};
            w_wait_nxt  = '0;
            w_state_nxt = StFetch;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state    <= StFetch;
            r_fetch_pc <= RESET_PC_AL;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem_instr[i] <= 32'h0;
                r_mem_pc[i]    <= 64'h0;
            end
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= Data;
                r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign Address    = {r_fetch_pc[63:2], 2'b00};
    assign InstrValid = (r_count != '0);
    assign Instr      = r_mem_instr[r_rd_ptr];
    assign InstrPC    = r_mem_pc[r_rd_ptr];
    assign Count      = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        CLK;
    logic        Reset_L;
    logic [63:0] Address;
    logic [31:0] Data;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic [2:0]  Count;

    // Second instance with a slow memory, only ever stalled.
    logic [63:0] Address3;
    logic [31:0] Data3;
    logic        InstrValid3;
    logic [31:0] Instr3;
    logic [63:0] InstrPC3;
    logic [2:0]  Count3;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction memory image.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h38) return 32'hD2800009;
        return 32'hF84003E9 + 32'(a[33:2]) * 32'h8001;
    endfunction

    assign Data  = mem_word(Address);
    assign Data3 = mem_word(Address3);

    instr_fetch_unit #(.FIFO_DEPTH(4), .RD_WAIT(1), .RESET_PC(64'h0)) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .Address    (Address),
        .Data       (Data),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .Count      (Count)
    );

    instr_fetch_unit #(.FIFO_DEPTH(4), .RD_WAIT(3), .RESET_PC(64'h0)) dut3 (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .Address    (Address3),
        .Data       (Data3),
        .Redirect   (1'b0),
        .RedirectPC (64'h0),
        .InstrValid (InstrValid3),
        .InstrReady (1'b0),
        .Instr      (Instr3),
        .InstrPC    (InstrPC3),
        .Count      (Count3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {word, pc}; a new word may be taken once the
    // address has been stable for RD_WAIT edges and there is room (or a pop).
    logic [95:0] m_q [$];
    logic [63:0] m_pc;
    int          m_age;

    task automatic model_reset();
        m_q.delete();
        m_pc  = 64'h0;
        m_age = 0;
    endtask

    task automatic model_step(input bit rdy, input bit redir, input logic [63:0] rpc);
        bit pop, push;
        if (redir) begin
            m_q.delete();
            m_pc  = {rpc[63:2], 2'b00};
            m_age = 0;
            return;
        end
        pop  = (m_q.size() != 0) && rdy;
        push = (m_age + 1 >= 1) && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back({mem_word(m_pc), m_pc});
            m_pc  = m_pc + 64'd4;
            m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, " Count"}, 64'(Count), 64'(m_q.size()));
        check({tag, " InstrValid"}, 64'(InstrValid), 64'(m_q.size() != 0));
        check({tag, " Address"}, Address, m_pc);
        if (m_q.size() != 0) begin
            check({tag, " InstrPC"}, InstrPC, m_q[0][63:0]);
            check({tag, " Instr"}, 64'(Instr), 64'(m_q[0][95:64]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " Count"}, 64'(Count), 64'h0);
        check({tag, " InstrValid"}, 64'(InstrValid), 64'h0);
        check({tag, " Instr"}, 64'(Instr), 64'h0);
        check({tag, " InstrPC"}, InstrPC, 64'h0);
        check({tag, " Address"}, Address, 64'h0);
        check({tag, " Address3"}, Address3, 64'h0);
        check({tag, " Count3"}, 64'(Count3), 64'h0);
    endtask

    task automatic do_reset();
        Redirect   = 1'b0;
        RedirectPC = 64'h0;
        InstrReady = 1'b0;
        @(negedge CLK);
        Reset_L = 1'b0;
        #2;
        check_reset_vals("reset");
        @(negedge CLK);
        Reset_L = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          rst;
        bit          ready;
        int          exp_count;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int thresh;
        bit rdy, rd;
        logic [63:0] rpc;

        Reset_L    = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 64'h0;
        InstrReady = 1'b0;

        // Straight-line fetch, then fill-to-stall and drain.
        tbl[0] = '{1'b1, 1'b1, 1, 64'h0, 32'hF84003E9, 64'h4};
        tbl[1] = '{1'b0, 1'b1, 1, 64'h4, 32'hF84083EA, 64'h8};
        tbl[2] = '{1'b0, 1'b1, 1, 64'h8, 32'hF84103EB, 64'hC};
        tbl[3] = '{1'b1, 1'b0, 1, 64'h0, 32'h0, 64'h4};
        tbl[4] = '{1'b0, 1'b0, 2, 64'h0, 32'h0, 64'h8};
        tbl[5] = '{1'b0, 1'b0, 3, 64'h0, 32'h0, 64'hC};
        for (int i = 6; i < 13; i++) tbl[i] = '{1'b0, 1'b0, 4, 64'h0, 32'h0, 64'h10};
        tbl[13] = '{1'b0, 1'b1, 4, 64'h4, 32'h0, 64'h14};
        tbl[14] = '{1'b0, 1'b1, 4, 64'h8, 32'h0, 64'h18};
        tbl[15] = '{1'b0, 1'b1, 4, 64'hC, 32'h0, 64'h1C};
        tbl[16] = '{1'b0, 1'b1, 4, 64'h10, 32'h0, 64'h20};
        for (int i = 3; i < 17; i++) tbl[i].exp_instr = mem_word(tbl[i].exp_pc);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) do_reset();
            InstrReady = tbl[i].ready;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d Count", i), 64'(Count), 64'(tbl[i].exp_count));
            check($sformatf("vec%0d Address", i), Address, tbl[i].exp_addr);
            if (tbl[i].exp_count != 0) begin
                check($sformatf("vec%0d InstrPC", i), InstrPC, tbl[i].exp_pc);
                check($sformatf("vec%0d Instr", i), 64'(Instr), 64'(tbl[i].exp_instr));
            end
        end

        // Redirect while three entries are buffered and a pop is offered.
        do_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("redir pre Count", 64'(Count), 64'd3);
        InstrReady = 1'b1;
        Redirect   = 1'b1;
        RedirectPC = 64'h3A;
        @(posedge CLK);
        #1;
        check("redir Count", 64'(Count), 64'd0);
        check("redir InstrValid", 64'(InstrValid), 64'd0);
        check("redir Address", Address, 64'h38);
        Redirect = 1'b0;
        @(posedge CLK);
        #1;
        check("redir first Count", 64'(Count), 64'd1);
        check("redir first InstrPC", InstrPC, 64'h38);
        check("redir first Instr", 64'(Instr), 64'hD2800009);

        // Slow memory: one push every third edge, address moves only then.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("rdwait3 edge%0d Address", k), Address3, 64'(4 * (k / 3)));
            check($sformatf("rdwait3 edge%0d Count", k), 64'(Count3), 64'(k / 3));
        end

        // Random traffic against the model, with a short mid-stream reset pulse.
        do_reset();
        thresh = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) thresh = int'($urandom_range(0, 100));
            rdy = ($urandom_range(0, 99) < thresh);
            rd  = ($urandom_range(0, 99) < 3);
            rpc = {$urandom, $urandom};
            InstrReady = rdy;
            Redirect   = rd;
            RedirectPC = rpc;
            @(posedge CLK);
            model_step(rdy, rd, rpc);
            #1;
            model_check($sformatf("rand%0d", c));
            if (c == 1500) begin
                Redirect = 1'b0;
                #2;
                Reset_L = 1'b0;
                #1;
                check_reset_vals("pulse");
                #2;
                Reset_L = 1'b1;
                model_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
